// File: rtl/tail_light_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tail_light_ctrl_pkg                                               |
// | Brief  : Shared types and default constants for the tail-light input       |
// |          controller (turn FSM encoding, timing defaults).                  |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
package tail_light_ctrl_pkg;

    // Turn-signal FSM encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_L_HELD = 3'd1,
        ST_R_HELD = 3'd2,
        ST_L_LANE = 3'd3,
        ST_R_LANE = 3'd4
    } turn_state_t;

    // Default timing constants
    localparam int unsigned c_debounce_cycles = 4;
    localparam int unsigned c_tick_div        = 8;
    localparam int unsigned c_tap_ticks       = 4;
    localparam int unsigned c_lane_ticks      = 12;

endpackage
`default_nettype wire

// File: rtl/tail_light_input_controller_debouncer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : input_debouncer                                                   |
// | Brief  : Two-flop synchroniser followed by a stable-count debouncer. The   |
// |          debounced value only flips after DEBOUNCE_CYCLES consecutive      |
// |          cycles of disagreement with the synchronised input.               |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module input_debouncer
    import tail_light_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_debounce_cycles
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic debounced
);

    localparam int unsigned           c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0]    c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               r_meta;
    logic               r_sync;
    logic               r_db;
    logic [c_cnt_w-1:0] r_cnt;

    // Bring the asynchronous raw input into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= raw;
            r_sync <= r_meta;
        end
    end

    // Count disagreement; flip the output on the edge the count reaches the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db  <= 1'b0;
            r_cnt <= '0;
        end else if (r_sync == r_db) begin
            r_cnt <= '0;
        end else if (r_cnt == c_cnt_last) begin
            r_db  <= r_sync;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign debounced = r_db;

endmodule
`default_nettype wire

// File: rtl/tail_light_input_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tail_light_input_controller                                       |
// | Brief  : Conditions raw brake / lever / hazard controls into clean brake,  |
// |          turn_left and turn_right commands, adds lane-change tap mode and  |
// |          toggled hazard mode, and generates the step_en rate pulse.        |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tail_light_input_controller
    import tail_light_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_debounce_cycles,
    parameter int unsigned TICK_DIV        = c_tick_div,
    parameter int unsigned TAP_TICKS       = c_tap_ticks,
    parameter int unsigned LANE_TICKS      = c_lane_ticks
) (
    input  logic clk,
    input  logic rst_n,
    input  logic brake_pedal,
    input  logic lever_left,
    input  logic lever_right,
    input  logic hazard_btn,
    output logic brake,
    output logic turn_left,
    output logic turn_right,
    output logic step_en,
    output logic hazard_active
);

    localparam int unsigned             c_tick_w    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_tick_w-1:0]     c_tick_last = c_tick_w'(TICK_DIV - 1);
    localparam int unsigned             c_hold_w    = $clog2(TAP_TICKS + 1);
    localparam logic [c_hold_w-1:0]     c_tap_max   = c_hold_w'(TAP_TICKS);
    localparam int unsigned             c_lane_w    = $clog2(LANE_TICKS + 1);
    localparam logic [c_lane_w-1:0]     c_lane_init = c_lane_w'(LANE_TICKS);
    localparam logic [c_lane_w-1:0]     c_lane_one  = c_lane_w'(1);

    logic w_db_brake;
    logic w_db_left;
    logic w_db_right;
    logic w_db_hazard;

    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_brake (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw       (brake_pedal),
        .debounced (w_db_brake)
    );

    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw       (lever_left),
        .debounced (w_db_left)
    );

    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw       (lever_right),
        .debounced (w_db_right)
    );

    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_hazard (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw       (hazard_btn),
        .debounced (w_db_hazard)
    );

    // ------------------------------------------------------------------
    // Step-rate tick: step_en is high while the counter sits on its last value
    // ------------------------------------------------------------------
    logic [c_tick_w-1:0] r_tick_cnt;
    logic [c_tick_w-1:0] w_tick_next;
    logic                r_step_en;

    assign w_tick_next = (r_tick_cnt == c_tick_last) ? '0 : r_tick_cnt + 1'b1;

    // Free-running tick divider with registered pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
            r_step_en  <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick_next;
            r_step_en  <= (w_tick_next == c_tick_last);
        end
    end

    // ------------------------------------------------------------------
    // Edge detection on debounced levers and hazard button
    // ------------------------------------------------------------------
    logic r_db_left_d;
    logic r_db_right_d;
    logic r_db_hazard_d;
    logic w_left_rise;
    logic w_right_rise;
    logic r_hazard_active;
    logic w_hazard_next;

    assign w_left_rise   = w_db_left & ~r_db_left_d;
    assign w_right_rise  = w_db_right & ~r_db_right_d;
    assign w_hazard_next = r_hazard_active ^ (w_db_hazard & ~r_db_hazard_d);

    // ------------------------------------------------------------------
    // Turn FSM next-state logic
    // ------------------------------------------------------------------
    turn_state_t          r_state;
    turn_state_t          w_state_next;
    logic [c_hold_w-1:0]  r_hold_cnt;
    logic [c_hold_w-1:0]  w_hold_next;
    logic [c_lane_w-1:0]  r_lane_cnt;
    logic [c_lane_w-1:0]  w_lane_next;

    // Lever-driven transitions; a release before TAP_TICKS ticks becomes a lane change
    always_comb begin
        w_state_next = r_state;
        w_hold_next  = r_hold_cnt;
        w_lane_next  = r_lane_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_db_left && !w_db_right) begin
                    w_state_next = ST_L_HELD;
                    w_hold_next  = '0;
                end else if (w_db_right && !w_db_left) begin
                    w_state_next = ST_R_HELD;
                    w_hold_next  = '0;
                end
            end
            ST_L_HELD: begin
                if (w_right_rise) begin
                    w_state_next = ST_IDLE;
                end else if (!w_db_left) begin
                    if (r_hold_cnt < c_tap_max) begin
                        w_state_next = ST_L_LANE;
                        w_lane_next  = c_lane_init;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else if (r_step_en && (r_hold_cnt != c_tap_max)) begin
                    w_hold_next = r_hold_cnt + 1'b1;
                end
            end
            ST_R_HELD: begin
                if (w_left_rise) begin
                    w_state_next = ST_IDLE;
                end else if (!w_db_right) begin
                    if (r_hold_cnt < c_tap_max) begin
                        w_state_next = ST_R_LANE;
                        w_lane_next  = c_lane_init;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else if (r_step_en && (r_hold_cnt != c_tap_max)) begin
                    w_hold_next = r_hold_cnt + 1'b1;
                end
            end
            ST_L_LANE: begin
                if (w_left_rise) begin
                    w_state_next = ST_L_HELD;
                    w_hold_next  = '0;
                end else if (w_right_rise) begin
                    w_state_next = ST_R_HELD;
                    w_hold_next  = '0;
                end else if (r_step_en) begin
                    if (r_lane_cnt <= c_lane_one) begin
                        w_state_next = ST_IDLE;
                        w_lane_next  = '0;
                    end else begin
                        w_lane_next = r_lane_cnt - 1'b1;
                    end
                end
            end
            ST_R_LANE: begin
                if (w_right_rise) begin
                    w_state_next = ST_R_HELD;
                    w_hold_next  = '0;
                end else if (w_left_rise) begin
                    w_state_next = ST_L_HELD;
                    w_hold_next  = '0;
                end else if (r_step_en) begin
                    if (r_lane_cnt <= c_lane_one) begin
                        w_state_next = ST_IDLE;
                        w_lane_next  = '0;
                    end else begin
                        w_lane_next = r_lane_cnt - 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_hold_next  = '0;
                w_lane_next  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered state, edge history and outputs decoded from next state
    // ------------------------------------------------------------------
    logic r_brake;
    logic r_turn_left;
    logic r_turn_right;

    // Hazard overrides only the decoded outputs; the FSM keeps tracking the levers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_hold_cnt      <= '0;
            r_lane_cnt      <= '0;
            r_db_left_d     <= 1'b0;
            r_db_right_d    <= 1'b0;
            r_db_hazard_d   <= 1'b0;
            r_hazard_active <= 1'b0;
            r_brake         <= 1'b0;
            r_turn_left     <= 1'b0;
            r_turn_right    <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_hold_cnt      <= w_hold_next;
            r_lane_cnt      <= w_lane_next;
            r_db_left_d     <= w_db_left;
            r_db_right_d    <= w_db_right;
            r_db_hazard_d   <= w_db_hazard;
            r_hazard_active <= w_hazard_next;
            r_brake         <= w_db_brake;
            r_turn_left     <= (w_state_next == ST_L_HELD) || (w_state_next == ST_L_LANE)
                               || w_hazard_next;
            r_turn_right    <= (w_state_next == ST_R_HELD) || (w_state_next == ST_R_LANE)
                               || w_hazard_next;
        end
    end

    assign brake         = r_brake;
    assign turn_left     = r_turn_left;
    assign turn_right    = r_turn_right;
    assign step_en       = r_step_en;
    assign hazard_active = r_hazard_active;

endmodule
`default_nettype wire

// File: tb/tb_tail_light_input_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_tail_light_input_controller                                    |
// | Brief  : Self-checking bench: table-driven steady-state vectors plus       |
// |          hand-written timing sequences, all checked through a scoreboard.  |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_tail_light_input_controller;

    logic clk;
    logic rst_n;
    logic brake_pedal;
    logic lever_left;
    logic lever_right;
    logic hazard_btn;
    logic brake;
    logic turn_left;
    logic turn_right;
    logic step_en;
    logic hazard_active;

    tail_light_input_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .brake_pedal   (brake_pedal),
        .lever_left    (lever_left),
        .lever_right   (lever_right),
        .hazard_btn    (hazard_btn),
        .brake         (brake),
        .turn_left     (turn_left),
        .turn_right    (turn_right),
        .step_en       (step_en),
        .hazard_active (hazard_active)
    );

    // Output bundle: {brake, turn_left, turn_right, step_en, hazard_active}
    logic [4:0] outs;
    assign outs = {brake, turn_left, turn_right, step_en, hazard_active};

    localparam logic [4:0] M_ALL   = 5'b11111;
    localparam logic [4:0] M_NOSTP = 5'b11101;
    localparam logic [4:0] M_BRK   = 5'b10000;
    localparam logic [4:0] M_LEFT  = 5'b01000;
    localparam logic [4:0] M_RIGHT = 5'b00100;
    localparam logic [4:0] M_TURNS = 5'b01100;
    localparam logic [4:0] M_STEP  = 5'b00010;
    localparam logic [4:0] M_HAZ   = 5'b00001;
    localparam logic [4:0] M_HZT   = 5'b01101;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;
    int r0     = 0;

    function automatic void check(string name, logic [4:0] act, logic [4:0] exp, logic [4:0] mask);
        n_cmp++;
        if ((act & mask) !== (exp & mask)) begin
            n_fail++;
            $display("FAIL %s: got %b required %b (mask %b) at cycle %0d", name, act, exp, mask, cyc);
        end
    endfunction

    typedef struct {
        string      name;
        int         due;
        logic [4:0] exp;
        logic [4:0] mask;
    } sb_t;

    sb_t sb_q[$];

    function automatic void push(string name, int due, logic [4:0] exp, logic [4:0] mask);
        sb_t e;
        e.name = name;
        e.due  = due;
        e.exp  = exp;
        e.mask = mask;
        sb_q.push_back(e);
    endfunction

    // Pop and compare every expectation that falls due on this cycle
    always @(negedge clk) begin
        for (int i = int'(sb_q.size()) - 1; i >= 0; i--) begin
            if (sb_q[i].due == cyc) begin
                check(sb_q[i].name, outs, sb_q[i].exp, sb_q[i].mask);
                sb_q.delete(i);
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        string      name;
        logic       brk;
        logic       lft;
        logic       rgt;
        logic       haz;
        int         hold;
        logic [4:0] exp;
        logic [4:0] mask;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int t;
        int t2;
        int e;
        int p12;
        int cnt;

        vecs[0]  = '{"v_idle",             1'b0, 1'b0, 1'b0, 1'b0, 12, 5'b00000, M_NOSTP};
        vecs[1]  = '{"v_brake",            1'b1, 1'b0, 1'b0, 1'b0, 12, 5'b10000, M_NOSTP};
        vecs[2]  = '{"v_brake_left",       1'b1, 1'b1, 1'b0, 1'b0, 12, 5'b11000, M_NOSTP};
        vecs[3]  = '{"v_left_then_right",  1'b0, 1'b1, 1'b1, 1'b0, 12, 5'b00000, M_NOSTP};
        vecs[4]  = '{"v_both_released",    1'b0, 1'b0, 1'b0, 1'b0, 12, 5'b00000, M_NOSTP};
        vecs[5]  = '{"v_right",            1'b0, 1'b0, 1'b1, 1'b0, 12, 5'b00100, M_NOSTP};
        vecs[6]  = '{"v_right_then_left",  1'b0, 1'b1, 1'b1, 1'b0, 12, 5'b00000, M_NOSTP};
        vecs[7]  = '{"v_released",         1'b0, 1'b0, 1'b0, 1'b0, 12, 5'b00000, M_NOSTP};
        vecs[8]  = '{"v_hazard_press",     1'b0, 1'b0, 1'b0, 1'b1, 12, 5'b01101, M_NOSTP};
        vecs[9]  = '{"v_hazard_release",   1'b0, 1'b0, 1'b0, 1'b0, 12, 5'b01101, M_NOSTP};
        vecs[10] = '{"v_hazard_press_off", 1'b0, 1'b0, 1'b0, 1'b1, 12, 5'b00000, M_NOSTP};
        vecs[11] = '{"v_hazard_rel_off",   1'b0, 1'b0, 1'b0, 1'b0, 12, 5'b00000, M_NOSTP};

        rst_n       = 1'b0;
        brake_pedal = 1'b0;
        lever_left  = 1'b0;
        lever_right = 1'b0;
        hazard_btn  = 1'b0;

        // Reset held for 10 cycles: every output low
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("reset_outputs", outs, 5'b00000, M_ALL);
        end

        // Release: step_en high in the cycle ending at edges 8, 16, 24
        rst_n = 1'b1;
        r0    = cyc;
        for (int k = 1; k <= 24; k++) begin
            push("step_en_phase", r0 + k, ((k % 8) == 7) ? 5'b00010 : 5'b00000, M_STEP);
            push("post_reset_quiet", r0 + k, 5'b00000, M_NOSTP);
        end
        tick(30);

        // Table-driven steady-state vectors
        foreach (vecs[i]) begin
            brake_pedal = vecs[i].brk;
            lever_left  = vecs[i].lft;
            lever_right = vecs[i].rgt;
            hazard_btn  = vecs[i].haz;
            push(vecs[i].name, cyc + vecs[i].hold, vecs[i].exp, vecs[i].mask);
            tick(vecs[i].hold);
        end

        // Bouncing brake pedal: no change during bounce, 1 exactly 7 edges after last transition
        t = cyc;
        for (int c = t + 1; c <= t + 26; c++) push("brake_bounce_low", c, 5'b00000, M_BRK);
        push("brake_settle_high", t + 27, 5'b10000, M_BRK);
        for (int i = 0; i < 20; i++) begin
            brake_pedal = (((i / 2) % 2) == 0);
            tick(1);
        end
        brake_pedal = 1'b1;
        tick(12);
        brake_pedal = 1'b0;
        tick(12);

        // Long hold of the left lever: no lane extension on release
        t = cyc;
        lever_left = 1'b1;
        push("long_left_before", t + 6, 5'b00000, M_LEFT);
        push("long_left_on", t + 7, 5'b01000, M_TURNS);
        push("long_left_right_off", t + 50, 5'b01000, M_TURNS);
        tick(100);
        t2 = cyc;
        lever_left = 1'b0;
        push("long_left_still_on", t2 + 6, 5'b01000, M_LEFT);
        push("long_left_off", t2 + 7, 5'b00000, M_TURNS);
        push("long_left_no_lane", t2 + 40, 5'b00000, M_TURNS);
        tick(50);

        // Tap of the right lever: 12 further step pulses of signalling
        t = cyc;
        lever_right = 1'b1;
        push("tap_right_on", t + 7, 5'b00100, M_TURNS);
        tick(20);
        t2 = cyc;
        lever_right = 1'b0;
        e   = t2 + 7;
        cnt = 0;
        p12 = e + 1;
        for (int c = e + 1; c < e + 400; c++) begin
            if (((c - r0) % 8) == 0) begin
                cnt++;
                if (cnt == 12) begin
                    p12 = c;
                    break;
                end
            end
        end
        push("tap_lane_entry", e, 5'b00100, M_TURNS);
        push("tap_lane_last", p12 - 1, 5'b00100, M_TURNS);
        push("tap_lane_done", p12, 5'b00000, M_TURNS);
        tick(p12 - cyc + 10);

        // Hazard on, then off again while the left lever is held
        t = cyc;
        hazard_btn = 1'b1;
        push("haz_not_yet", t + 6, 5'b00000, M_HAZ);
        push("haz_on", t + 7, 5'b01101, M_HZT);
        tick(10);
        hazard_btn = 1'b0;
        tick(10);
        lever_left = 1'b1;
        push("haz_with_left", cyc + 12, 5'b01101, M_HZT);
        tick(12);
        t = cyc;
        hazard_btn = 1'b1;
        push("haz_off_left_held", t + 7, 5'b01000, M_HZT);
        tick(10);
        hazard_btn = 1'b0;
        tick(40);
        lever_left = 1'b0;
        push("haz_left_released", cyc + 7, 5'b00000, M_HZT);
        tick(12);

        // Bouncy press and bouncy release: exactly one toggle
        t = cyc;
        push("bouncy_pre", t + 10, 5'b00000, M_HAZ);
        push("bouncy_on", t + 11, 5'b00001, M_HAZ);
        push("bouncy_held", t + 16, 5'b00001, M_HAZ);
        push("bouncy_single_toggle", t + 35, 5'b01101, M_HZT);
        for (int i = 0; i < 28; i++) begin
            hazard_btn = (i < 4) ? ((i % 2) == 0) : ((i < 16) ? 1'b1 : (i == 17));
            tick(1);
        end
        tick(10);
        t = cyc;
        hazard_btn = 1'b1;
        push("haz_final_off", t + 7, 5'b00000, M_HZT);
        tick(10);
        hazard_btn = 1'b0;
        tick(12);

        // Right lever cancels a left lane change
        lever_left = 1'b1;
        tick(20);
        t2 = cyc;
        lever_left = 1'b0;
        push("cancel_lane_left", t2 + 7, 5'b01000, M_TURNS);
        tick(15);
        t = cyc;
        lever_right = 1'b1;
        push("cancel_before", t + 6, 5'b01000, M_TURNS);
        push("cancel_to_right", t + 7, 5'b00100, M_TURNS);
        tick(50);
        lever_right = 1'b0;
        push("cancel_released", cyc + 7, 5'b00000, M_TURNS);
        tick(12);

        // Reset asserted in the middle of a lane change: aborts immediately, no resume
        lever_left = 1'b1;
        tick(20);
        t2 = cyc;
        lever_left = 1'b0;
        push("lane_before_reset", t2 + 18, 5'b01000, M_TURNS);
        tick(20);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_mid_lane", outs, 5'b00000, M_ALL);
        tick(3);
        rst_n = 1'b1;
        r0 = cyc;
        for (int k = 7; k < 120; k += 8)
            push("no_resume_after_reset", r0 + k, 5'b00000, M_TURNS);
        push("step_restart_hi", r0 + 7, 5'b00010, M_STEP);
        push("step_restart_lo", r0 + 8, 5'b00000, M_STEP);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(negedge clk);
        tick(1);
        foreach (sb_q[i]) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_expired %s: never compared, required %b", sb_q[i].name, sb_q[i].exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global time limit
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
